// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes and FSM states.
// Imported by the lane aligner and the top level.
package load_store_unit_pkg;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Lane steering: load extract/extend, sub-word store merge, misalign detect.
// Purely combinational; size 2'b11 behaves as a word.
module lsu_lane_align
   import load_store_unit_pkg::*;
(
   input  logic [31:0] word_in,
   input  logic [31:0] wdata,
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic        is_unsigned,
   output logic [31:0] load_data,
   output logic [31:0] word_out,
   output logic        misalign
);

   logic [31:0] shifted;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      shifted  = word_in >> {offset, 3'b000};
      lane_b   = shifted[7:0];
      lane_h   = offset[1] ? word_in[31:16] : word_in[15:0];
      word_out = word_in;
      case (size)
         SIZE_B: begin
            load_data = {{24{~is_unsigned & lane_b[7]}}, lane_b};
            word_out[{offset, 3'b000} +: 8] = wdata[7:0];
            misalign  = 1'b0;
         end
         SIZE_H: begin
            load_data = {{16{~is_unsigned & lane_h[15]}}, lane_h};
            word_out[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            misalign  = offset[0];
         end
         default: begin
            load_data = word_in;
            word_out  = wdata;
            misalign  = |offset;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the CPU memory stage and a word-wide data memory.
// Sub-word stores use a two-cycle read-modify-write that stalls the CPU.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cpu_req,
   input  logic             cpu_we,
   input  logic [1:0]       cpu_size,
   input  logic             cpu_unsigned,
   input  logic [31:0]      cpu_addr,
   input  logic [31:0]      cpu_wdata,
   output logic [31:0]      cpu_rdata,
   output logic             cpu_stall,
   output logic             cpu_misalign,
   output logic             err_sticky,
   output logic [CNT_W-1:0] load_cnt,
   output logic [CNT_W-1:0] store_cnt,
   output logic [31:0]      mem_access_addr,
   output logic [31:0]      mem_write_data,
   output logic             mem_write_en,
   output logic             mem_read,
   input  logic [31:0]      mem_read_data
);

   lsu_state_t  state_q, state_d;
   logic [31:0] merged_q, addr_q;
   logic [31:0] load_data, merged;
   logic        mis, idle_ok, ld_inc, st_inc, rmw_start;

   lsu_lane_align u_align (
      .word_in     (mem_read_data),
      .wdata       (cpu_wdata),
      .size        (cpu_size),
      .offset      (cpu_addr[1:0]),
      .is_unsigned (cpu_unsigned),
      .load_data   (load_data),
      .word_out    (merged),
      .misalign    (mis)
   );

   // A misaligned request is reported but never touches memory or the FSM.
   assign idle_ok   = (state_q == ST_IDLE) && cpu_req && !mis;
   assign ld_inc    = idle_ok && !cpu_we;
   assign rmw_start = idle_ok && cpu_we && !cpu_size[1];
   assign st_inc    = (idle_ok && cpu_we && cpu_size[1]) ||
                      (state_q == ST_WRITE);

   always_comb begin
      state_d         = state_q;
      cpu_rdata       = '0;
      cpu_stall       = 1'b0;
      cpu_misalign    = 1'b0;
      mem_access_addr = '0;
      mem_write_data  = '0;
      mem_write_en    = 1'b0;
      mem_read        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cpu_req) begin
               mem_access_addr = {cpu_addr[31:2], 2'b00};
               cpu_misalign    = mis;
               if (!mis) begin
                  if (!cpu_we) begin
                     mem_read  = 1'b1;
                     cpu_rdata = load_data;
                  end else if (cpu_size[1]) begin
                     mem_write_en   = 1'b1;
                     mem_write_data = cpu_wdata;
                  end else begin
                     mem_read  = 1'b1;
                     cpu_stall = 1'b1;
                     state_d   = ST_WRITE;
                  end
               end
            end
         end
         ST_WRITE: begin
            mem_access_addr = addr_q;
            mem_write_data  = merged_q;
            mem_write_en    = 1'b1;
            state_d         = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         merged_q   <= '0;
         addr_q     <= '0;
         load_cnt   <= '0;
         store_cnt  <= '0;
         err_sticky <= 1'b0;
      end else begin
         state_q <= state_d;
         if (rmw_start) begin
            merged_q <= merged;
            addr_q   <= {cpu_addr[31:2], 2'b00};
         end
         if (ld_inc)
            load_cnt <= load_cnt + CNT_W'(1);
         if (st_inc)
            store_cnt <= store_cnt + CNT_W'(1);
         if (state_q == ST_IDLE && cpu_req && mis)
            err_sticky <= 1'b1;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random traffic,
// checked every cycle against a byte-level memory/transaction model.
module tb_load_store_unit;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset, init;
   logic          cpu_req, cpu_we, cpu_unsigned;
   logic [1:0]    cpu_size;
   logic [31:0]   cpu_addr, cpu_wdata;
   logic [31:0]   cpu_rdata, mem_access_addr, mem_write_data, mem_read_data;
   logic          cpu_stall, cpu_misalign, err_sticky;
   logic          mem_write_en, mem_read;
   logic [CW-1:0] load_cnt, store_cnt;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] mem [16];
   logic [31:0] ref_mem [16];
   logic [31:0] seed;

   load_store_unit #(.CNT_W(CW)) dut (
      .clk             (clk),
      .reset           (reset),
      .cpu_req         (cpu_req),
      .cpu_we          (cpu_we),
      .cpu_size        (cpu_size),
      .cpu_unsigned    (cpu_unsigned),
      .cpu_addr        (cpu_addr),
      .cpu_wdata       (cpu_wdata),
      .cpu_rdata       (cpu_rdata),
      .cpu_stall       (cpu_stall),
      .cpu_misalign    (cpu_misalign),
      .err_sticky      (err_sticky),
      .load_cnt        (load_cnt),
      .store_cnt       (store_cnt),
      .mem_access_addr (mem_access_addr),
      .mem_write_data  (mem_write_data),
      .mem_write_en    (mem_write_en),
      .mem_read        (mem_read),
      .mem_read_data   (mem_read_data)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(int i);
      return seed ^ (32'(i + 1) * 32'h9E37_79B9);
   endfunction

   assign mem_read_data = mem[mem_access_addr[5:2]];

   always @(posedge clk) begin
      if (init) begin
         for (int i = 0; i < 16; i++)
            mem[i] <= init_word(i);
      end else if (mem_write_en) begin
         mem[mem_access_addr[5:2]] <= mem_write_data;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ext(input logic [31:0] w,
                                       input logic [1:0] sz,
                                       input logic u,
                                       input logic [1:0] off);
      logic [31:0] v;
      v = w >> (8 * int'(off));
      if (sz == 2'd0) begin
         v = v & 32'hFF;
         if (!u && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         v = v & 32'hFFFF;
         if (!u && v[15]) v = v | 32'hFFFF_0000;
      end
      return v;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] w,
                                         input logic [31:0] wd,
                                         input logic [1:0] sz,
                                         input logic [1:0] off);
      logic [31:0] r;
      int nb;
      r  = w;
      nb = (sz == 2'd0) ? 1 : 2;
      for (int k = 0; k < nb; k++)
         r[8 * (int'(off) + k) +: 8] = wd[8 * k +: 8];
      return r;
   endfunction

   logic          m_pend, m_sticky;
   logic [31:0]   m_paddr, m_pword;
   logic [CW-1:0] m_ld, m_st;

   always @(negedge clk) begin
      logic [31:0] e_rdata, e_addr, e_wdata;
      logic        e_we, e_rd, e_stall, e_mis, mis;
      logic [3:0]  idx;
      logic [1:0]  off;
      if (reset) begin
         m_pend = 1'b0; m_sticky = 1'b0; m_ld = '0; m_st = '0;
         if (init)
            for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
      end else begin
         idx = cpu_addr[5:2];
         off = cpu_addr[1:0];
         mis = (cpu_size == 2'd1 && off[0]) || (cpu_size[1] && off != 2'd0);
         e_rdata = '0; e_addr = '0; e_wdata = '0;
         e_we = 0; e_rd = 0; e_stall = 0; e_mis = 0;
         if (m_pend) begin
            e_we = 1; e_addr = m_paddr; e_wdata = m_pword;
         end else if (cpu_req) begin
            e_addr = cpu_addr & ~32'd3;
            e_mis  = mis;
            if (!mis) begin
               if (!cpu_we) begin
                  e_rd = 1;
                  e_rdata = ext(ref_mem[idx], cpu_size, cpu_unsigned, off);
               end else if (cpu_size[1]) begin
                  e_we = 1; e_wdata = cpu_wdata;
               end else begin
                  e_rd = 1; e_stall = 1;
               end
            end
         end
         chk("cpu_rdata", cpu_rdata, e_rdata);
         chk("mem_access_addr", mem_access_addr, e_addr);
         chk("mem_write_data", mem_write_data, e_wdata);
         chk("mem_write_en", 32'(mem_write_en), 32'(e_we));
         chk("mem_read", 32'(mem_read), 32'(e_rd));
         chk("cpu_stall", 32'(cpu_stall), 32'(e_stall));
         chk("cpu_misalign", 32'(cpu_misalign), 32'(e_mis));
         chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
         chk("load_cnt", 32'(load_cnt), 32'(m_ld));
         chk("store_cnt", 32'(store_cnt), 32'(m_st));
         if (m_pend) begin
            ref_mem[m_paddr[5:2]] = m_pword;
            m_st++;
            m_pend = 1'b0;
         end else if (cpu_req) begin
            if (mis) m_sticky = 1'b1;
            else if (!cpu_we) m_ld++;
            else if (cpu_size[1]) begin
               ref_mem[idx] = cpu_wdata;
               m_st++;
            end else begin
               m_pend  = 1'b1;
               m_paddr = cpu_addr & ~32'd3;
               m_pword = merge(ref_mem[idx], cpu_wdata, cpu_size, off);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set(input logic we, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] wd);
      cpu_req = 1'b1; cpu_we = we; cpu_size = sz;
      cpu_unsigned = u; cpu_addr = a; cpu_wdata = wd;
   endtask

   task automatic op(input logic we, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] wd);
      logic mis;
      set(we, sz, u, a, wd);
      mis = (sz == 2'd1 && a[0]) || (sz[1] && a[1:0] != 2'd0);
      step();
      if (we && !sz[1] && !mis) step();
   endtask

   initial begin
      logic [31:0] a, old20;
      logic [1:0]  sz;
      seed  = $urandom;
      reset = 1'b1; init = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_size = 0; cpu_unsigned = 0;
      cpu_addr = 0; cpu_wdata = 0;
      repeat (2) step();
      chk("rst_write_en", 32'(mem_write_en), 0);
      chk("rst_store_cnt", 32'(store_cnt), 0);
      chk("rst_err_sticky", 32'(err_sticky), 0);
      init = 1'b0; reset = 1'b0;
      step();

      set(1, 2'd2, 0, 32'h10, 32'hDEAD_BEEF);
      @(negedge clk);
      chk("sw_write_en", 32'(mem_write_en), 1);
      chk("sw_stall", 32'(cpu_stall), 0);
      step();
      chk("sw_store_cnt", 32'(store_cnt), 1);
      set(0, 2'd2, 0, 32'h10, 0);
      @(negedge clk);
      chk("lw_rdata", cpu_rdata, 32'hDEAD_BEEF);
      step();

      set(1, 2'd0, 0, 32'h11, 32'h1234_56AA);
      @(negedge clk);
      chk("sb_stall", 32'(cpu_stall), 1);
      step();
      @(negedge clk);
      chk("sb_write_data", mem_write_data, 32'hDEAD_AAEF);
      chk("sb_store_cnt_pre", 32'(store_cnt), 1);
      step();
      chk("sb_store_cnt", 32'(store_cnt), 2);

      set(0, 2'd0, 0, 32'h12, 0);
      @(negedge clk); chk("lb_rdata", cpu_rdata, 32'hFFFF_FFAD); step();
      set(0, 2'd0, 1, 32'h12, 0);
      @(negedge clk); chk("lbu_rdata", cpu_rdata, 32'h0000_00AD); step();
      set(0, 2'd1, 0, 32'h12, 0);
      @(negedge clk); chk("lh_rdata", cpu_rdata, 32'hFFFF_DEAD); step();
      set(0, 2'd1, 1, 32'h10, 0);
      @(negedge clk); chk("lhu_rdata", cpu_rdata, 32'h0000_AAEF); step();

      set(1, 2'd1, 0, 32'h11, 32'hBEEF);
      @(negedge clk);
      chk("sh_misalign", 32'(cpu_misalign), 1);
      chk("sh_mis_strobes", 32'({mem_write_en, mem_read}), 0);
      step();
      chk("mis_sticky", 32'(err_sticky), 1);
      chk("mis_store_cnt", 32'(store_cnt), 2);
      chk("mis_load_cnt", 32'(load_cnt), 5);
      set(0, 2'd2, 0, 32'h10, 0);
      @(negedge clk); chk("post_mis_lw", cpu_rdata, 32'hDEAD_AAEF); step();

      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(7) == 0) begin
            cpu_req = 1'b0;
            step();
         end else begin
            sz = 2'($urandom_range(3));
            a  = $urandom;
            if ($urandom_range(3) != 0)
               a = a & ((sz == 2'd0) ? 32'hFFFF_FFFF :
                        (sz == 2'd1) ? 32'hFFFF_FFFE : 32'hFFFF_FFFC);
            op(1'($urandom_range(1)), sz, 1'($urandom_range(1)), a, $urandom);
         end
      end

      cpu_req = 1'b0;
      step();
      old20 = mem[8];
      set(1, 2'd1, 0, 32'h20, ~old20);
      step();
      chk("mid_write_en", 32'(mem_write_en), 1);
      cpu_req = 1'b0;
      reset = 1'b1;
      #1;
      chk("rst_mid_write_en", 32'(mem_write_en), 0);
      chk("rst_mid_outputs",
          cpu_rdata | mem_access_addr | mem_write_data, 0);
      chk("rst_mid_flags",
          32'({mem_read, cpu_stall, cpu_misalign, err_sticky}), 0);
      chk("rst_mid_cnts", 32'({load_cnt, store_cnt}), 0);
      repeat (2) step();
      reset = 1'b0;
      step();
      chk("mem20_kept", mem[8], old20);

      for (int n = 0; n < 17; n++)
         op(1, 2'd2, 0, $urandom & 32'hFFFF_FFFC, $urandom);
      cpu_req = 1'b0;
      step();
      chk("wrap_store_cnt", 32'(store_cnt), 1);
      chk("wrap_load_cnt", 32'(load_cnt), 0);

      repeat (2) step();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
